// File: rtl/bldcm_hall_sensor_pkg.sv
// Shared definitions for the BLDC Hall-sensor receiver: register map, status bits,
// response codes and the Hall-to-phase decode table shared with the drive core.
package bldcm_hall_sensor_pkg;

    localparam int unsigned DATA_W             = 32;
    localparam int unsigned ADDR_W             = 2;
    localparam int unsigned RESP_W             = 2;
    localparam int unsigned CODE_W             = 3;
    localparam int unsigned PHASE_W            = 3;
    localparam int unsigned FILTER_CNT_W       = 8;
    localparam int unsigned TOTAL_PHASE_STAGES = 6;

    localparam logic [ADDR_W-1:0] ADDR_CTRL     = 2'd0;
    localparam logic [ADDR_W-1:0] ADDR_STATUS   = 2'd1;
    localparam logic [ADDR_W-1:0] ADDR_PERIOD   = 2'd2;
    localparam logic [ADDR_W-1:0] ADDR_POSITION = 2'd3;

    localparam int unsigned CTRL_ENABLE_BIT    = 0;
    localparam int unsigned CTRL_CLEAR_BIT     = 1;
    localparam int unsigned STATUS_PHASE_LSB   = 0;
    localparam int unsigned STATUS_VALID_BIT   = 3;
    localparam int unsigned STATUS_DIR_BIT     = 4;
    localparam int unsigned STATUS_STALL_BIT   = 5;
    localparam int unsigned STATUS_INVALID_BIT = 8;
    localparam int unsigned STATUS_SKIP_BIT    = 9;

    localparam logic [RESP_W-1:0] RESP_OKAY   = 2'b00;
    localparam logic [RESP_W-1:0] RESP_SLVERR = 2'b10;

    typedef struct packed {
        logic               legal;
        logic [PHASE_W-1:0] phase;
    } hall_decode_t;

    // Hall {U,V,W} to commutation phase; 000 and 111 are illegal
    function automatic hall_decode_t hall_decode(input logic [CODE_W-1:0] code);
        hall_decode_t d;
        d.legal = 1'b1;
        d.phase = '0;
        case (code)
            3'b101:  d.phase = 3'd0;
            3'b100:  d.phase = 3'd1;
            3'b110:  d.phase = 3'd2;
            3'b010:  d.phase = 3'd3;
            3'b011:  d.phase = 3'd4;
            3'b001:  d.phase = 3'd5;
            default: d.legal = 1'b0;
        endcase
        return d;
    endfunction

    function automatic logic [PHASE_W-1:0] phase_next(input logic [PHASE_W-1:0] p);
        return (p == PHASE_W'(TOTAL_PHASE_STAGES - 1)) ? '0 : p + PHASE_W'(1);
    endfunction

    function automatic logic [PHASE_W-1:0] phase_prev(input logic [PHASE_W-1:0] p);
        return (p == '0) ? PHASE_W'(TOTAL_PHASE_STAGES - 1) : p - PHASE_W'(1);
    endfunction

endpackage

// File: rtl/bldcm_hall_sensor_filter.sv
// Hall input conditioning: 2-flop synchronizer, optional inversion and, when
// MBLDCM_HALL_DEBOUNCE_EN is defined, a stable-count debounce filter.
module bldcm_hall_sensor_filter
    import bldcm_hall_sensor_pkg::*;
#(
    parameter int unsigned FILTER_CYCLES = 16,
    parameter bit          INVERT_HALL   = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CODE_W-1:0] hall,
    output logic [CODE_W-1:0] code_c,
    output logic              change_c
);

    localparam logic [CODE_W-1:0] IDLE_CODE = {CODE_W{INVERT_HALL}};

    if (FILTER_CYCLES < 1 || FILTER_CYCLES > 255) begin : g_bad_filter_cycles
        $error("FILTER_CYCLES must be in 1..255");
    end

    logic [CODE_W-1:0] sync1;
    logic [CODE_W-1:0] sync2;
    logic [CODE_W-1:0] sampled;
    logic [CODE_W-1:0] accepted;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= hall;
            sync2 <= sync1;
        end
    end

    assign sampled = INVERT_HALL ? ~sync2 : sync2;

`ifdef MBLDCM_HALL_DEBOUNCE_EN
    localparam logic [FILTER_CNT_W-1:0] LAST_COUNT = FILTER_CNT_W'(FILTER_CYCLES - 1);

    logic [CODE_W-1:0]       candidate;
    logic [FILTER_CNT_W-1:0] stable_cnt;

    // Candidate restarts its count on any change; accepted once the count reaches the limit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            candidate  <= IDLE_CODE;
            stable_cnt <= '0;
            accepted   <= IDLE_CODE;
        end else begin
            if (sampled != candidate) begin
                candidate  <= sampled;
                stable_cnt <= '0;
            end else if (stable_cnt != LAST_COUNT) begin
                stable_cnt <= stable_cnt + FILTER_CNT_W'(1);
            end
            if (change_c) begin
                accepted <= candidate;
            end
        end
    end

    assign code_c   = candidate;
    assign change_c = (stable_cnt == LAST_COUNT) && (candidate != accepted);
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            accepted <= IDLE_CODE;
        end else begin
            accepted <= sampled;
        end
    end

    assign code_c   = sampled;
    assign change_c = (sampled != accepted);
`endif

endmodule

// File: rtl/bldcm_hall_sensor.sv
// BLDC Hall-sensor receiver: phase decode, direction, period and position with an
// Avalon-MM register port. Debounce is compiled in with MBLDCM_HALL_DEBOUNCE_EN.
module bldcm_hall_sensor
    import bldcm_hall_sensor_pkg::*;
#(
    parameter int unsigned FILTER_CYCLES = 16,
    parameter bit          INVERT_HALL   = 1'b0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [ADDR_W-1:0]  addr,
    input  logic               read,
    output logic [DATA_W-1:0]  rdata,
    input  logic               write,
    input  logic [DATA_W-1:0]  wdata,
    output logic [RESP_W-1:0]  resp,
    input  logic               hall_u,
    input  logic               hall_v,
    input  logic               hall_w,
    output logic [PHASE_W-1:0] phase,
    output logic               phase_valid,
    output logic               direction
);

    localparam logic [DATA_W-1:0] COUNT_MAX = '1;

    logic [CODE_W-1:0] code_c;
    logic              change_c;
    hall_decode_t      dec_c;
    logic              fwd_c;
    logic              rev_c;
    logic              step_c;
    logic              skip_evt_c;
    logic              invalid_evt_c;
    logic              wr_ctrl_c;
    logic              wr_status_c;
    logic              wr_period_c;
    logic              wr_pos_c;
    logic [DATA_W-1:0] status_c;
    logic [DATA_W-1:0] rd_mux_c;

    logic              enable;
    logic [DATA_W-1:0] position;
    logic [DATA_W-1:0] period;
    logic [DATA_W-1:0] period_cnt;
    logic              step_seen;
    logic              stall;
    logic              invalid;
    logic              skip;

    bldcm_hall_sensor_filter #(
        .FILTER_CYCLES (FILTER_CYCLES),
        .INVERT_HALL   (INVERT_HALL)
    ) u_filter (
        .clk      (clk),
        .rst_n    (rst_n),
        .hall     ({hall_u, hall_v, hall_w}),
        .code_c   (code_c),
        .change_c (change_c)
    );

    // Step classification of each accepted code against the current phase
    always_comb begin
        dec_c         = hall_decode(code_c);
        fwd_c         = 1'b0;
        rev_c         = 1'b0;
        skip_evt_c    = 1'b0;
        invalid_evt_c = change_c && !dec_c.legal;
        if (change_c && dec_c.legal && phase_valid) begin
            if (dec_c.phase == phase_next(phase)) begin
                fwd_c = 1'b1;
            end else if (dec_c.phase == phase_prev(phase)) begin
                rev_c = 1'b1;
            end else begin
                skip_evt_c = 1'b1;
            end
        end
        step_c = fwd_c || rev_c;
    end

    assign wr_ctrl_c   = write && (addr == ADDR_CTRL);
    assign wr_status_c = write && (addr == ADDR_STATUS);
    assign wr_period_c = write && (addr == ADDR_PERIOD);
    assign wr_pos_c    = write && (addr == ADDR_POSITION);

    always_comb begin
        status_c = '0;
        status_c[STATUS_PHASE_LSB +: PHASE_W] = phase;
        status_c[STATUS_VALID_BIT]            = phase_valid;
        status_c[STATUS_DIR_BIT]              = direction;
        status_c[STATUS_STALL_BIT]            = stall;
        status_c[STATUS_INVALID_BIT]          = invalid;
        status_c[STATUS_SKIP_BIT]             = skip;
    end

    always_comb begin
        rd_mux_c = '0;
        case (addr)
            ADDR_CTRL:     rd_mux_c = DATA_W'(enable);
            ADDR_STATUS:   rd_mux_c = status_c;
            ADDR_PERIOD:   rd_mux_c = period;
            ADDR_POSITION: rd_mux_c = position;
            default:       rd_mux_c = '0;
        endcase
    end

    // Rotor state tracks the sensors regardless of ENABLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase       <= '0;
            phase_valid <= 1'b0;
            direction   <= 1'b0;
        end else begin
            if (change_c && dec_c.legal) begin
                phase       <= dec_c.phase;
                phase_valid <= 1'b1;
            end
            if (fwd_c) begin
                direction <= 1'b0;
            end else if (rev_c) begin
                direction <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enable <= 1'b0;
        end else if (wr_ctrl_c) begin
            enable <= wdata[CTRL_ENABLE_BIT];
        end
    end

    // Firmware load or clear takes priority over a concurrent step
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            position <= '0;
        end else if (wr_pos_c) begin
            position <= wdata;
        end else if (wr_ctrl_c && wdata[CTRL_CLEAR_BIT]) begin
            position <= '0;
        end else if (enable && fwd_c) begin
            position <= position + DATA_W'(1);
        end else if (enable && rev_c) begin
            position <= position - DATA_W'(1);
        end
    end

    // Step-to-step cycle counter; PERIOD is published from the second step onward
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period     <= '0;
            period_cnt <= '0;
            step_seen  <= 1'b0;
            stall      <= 1'b0;
        end else if (enable) begin
            if (step_c) begin
                if (step_seen) begin
                    period <= (period_cnt == COUNT_MAX) ? COUNT_MAX : period_cnt + DATA_W'(1);
                end
                period_cnt <= '0;
                step_seen  <= 1'b1;
                stall      <= 1'b0;
            end else if (period_cnt == COUNT_MAX) begin
                stall <= 1'b1;
            end else begin
                period_cnt <= period_cnt + DATA_W'(1);
            end
        end
    end

    // Sticky error flags; a new error in the same cycle as W1C keeps the flag set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            invalid <= 1'b0;
            skip    <= 1'b0;
        end else begin
            invalid <= (invalid && !(wr_status_c && wdata[STATUS_INVALID_BIT]))
                       || (enable && invalid_evt_c);
            skip    <= (skip && !(wr_status_c && wdata[STATUS_SKIP_BIT]))
                       || (enable && skip_evt_c);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
            resp  <= RESP_OKAY;
        end else begin
            if (read) begin
                rdata <= rd_mux_c;
            end
            resp <= wr_period_c ? RESP_SLVERR : RESP_OKAY;
        end
    end

endmodule
